shift_reg_sipo_rx: RTL and testbench

//  Receive end of the serial shift-register link: deserializes the 1-bit stream driven by the

---
 rtl/shift_reg_pkg.sv | 21 ++
 rtl/shift_reg_sipo_core.sv | 67 ++++++
 rtl/shift_reg_sipo_rx.sv | 87 ++++++++
 tb/tb_shift_reg_sipo_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the serial shift-register link (tx and rx ends).
// SHIFT_REG_PARITY_EN adds one odd-parity bit to every frame.
package shift_reg_pkg;

  localparam int SR_WIDTH_DEF = 8;
  localparam int SR_CNT_W_DEF = $clog2(SR_WIDTH_DEF + 1);

  typedef enum logic {
    ST_EMPTY,
    ST_FULL
  } sr_state_e;

  function automatic int sr_frame_len(input int width);
`ifdef SHIFT_REG_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

endpackage

// File: rtl/shift_reg_sipo_core.sv
// Deserializer datapath: shift register, bit counter, completion pulse.
// SHIFT_REG_PARITY_EN: the trailing parity bit is counted but not shifted in.
module shift_reg_sipo_core
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH_DEF,
  parameter int MSB_FIRST = 1,
  parameter int CW        = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin_i,
  input  logic             shift_i,
  input  logic             clear_i,
  output logic [WIDTH-1:0] word_o,
  output logic             done_o,
  output logic [CW-1:0]    bit_cnt_o
);

  localparam int FRAME = sr_frame_len(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d, shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             take, last;

  if (MSB_FIRST != 0) begin : g_msb
    assign shifted = {sr_q[WIDTH-2:0], sin_i};
  end else begin : g_lsb
    assign shifted = {sin_i, sr_q[WIDTH-1:1]};
  end

  assign take   = shift_i && !clear_i;
  assign last   = (cnt_q == CW'(FRAME - 1));
  assign done_o = take && last;

  // With parity the final edge carries the parity bit, so the word is already complete.
  if (FRAME == WIDTH) begin : g_nopar
    assign word_o = shifted;
  end else begin : g_par
    assign word_o = sr_q;
  end

  assign bit_cnt_o = cnt_q;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (take) begin
      if (cnt_q < CW'(WIDTH)) sr_d = shifted;
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/shift_reg_sipo_rx.sv
// Serial-in receiver: one buffered output word, sticky overrun.
// SHIFT_REG_PARITY_EN adds odd-parity checking and the parity_err port.
module shift_reg_sipo_rx
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = SR_WIDTH_DEF,
  parameter int MSB_FIRST = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sin,
  input  logic                       shift,
  input  logic                       clear,
  output logic [WIDTH-1:0]           data_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       overrun,
`ifdef SHIFT_REG_PARITY_EN
  output logic                       parity_err,
`endif
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH + 1);

  sr_state_e        state_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             ovr_q;

  shift_reg_sipo_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST),
    .CW       (CW)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .sin_i    (sin),
    .shift_i  (shift),
    .clear_i  (clear),
    .word_o   (word),
    .done_o   (done),
    .bit_cnt_o(bit_cnt)
  );

`ifdef SHIFT_REG_PARITY_EN
  logic perr_q;
  logic par_ok;
  // On the completing edge sin is the parity bit.
  assign par_ok     = ^{word, sin};
  assign parity_err = perr_q;

  always_ff @(posedge clk) begin
    if (reset || clear) perr_q <= 1'b0;
    else if (done && !par_ok) perr_q <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      if (clear) ovr_q <= 1'b0;
      unique case (state_q)
        ST_EMPTY: begin
          if (done) begin
            state_q <= ST_FULL;
            data_q  <= word;
          end
        end
        ST_FULL: begin
          if (done && out_ready) data_q <= word;
          else if (done) ovr_q <= 1'b1;
          else if (out_ready) state_q <= ST_EMPTY;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign out_valid = (state_q == ST_FULL);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Scoreboard bench for shift_reg_sipo_rx (WIDTH=8, MSB_FIRST=1).
module tb_shift_reg_sipo_rx;

  localparam int W = 8;
`ifdef SHIFT_REG_PARITY_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic         clk = 1'b0;
  logic         reset, sin, shift, clear, out_ready;
  logic [W-1:0] data_out;
  logic         out_valid, overrun;
  logic [3:0]   bit_cnt;
`ifdef SHIFT_REG_PARITY_EN
  logic         parity_err;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q[$];
  bit           bq[$];
  bit           m_ovr = 1'b0;
  bit           m_perr = 1'b0;
  bit           mon_en = 1'b0;

  always #5 clk = ~clk;

  shift_reg_sipo_rx #(.WIDTH(W), .MSB_FIRST(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .sin       (sin),
    .shift     (shift),
    .clear     (clear),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun),
`ifdef SHIFT_REG_PARITY_EN
    .parity_err(parity_err),
`endif
    .bit_cnt   (bit_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits collected into a queue, words built from the frame.
  always @(posedge clk) begin : model
    logic [W-1:0] w;
    bit           par;
    if (reset) begin
      exp_q.delete();
      bq.delete();
      m_ovr  = 1'b0;
      m_perr = 1'b0;
    end else if (clear) begin
      bq.delete();
      m_ovr  = 1'b0;
      m_perr = 1'b0;
    end else if (shift) begin
      bq.push_back(sin);
      if (bq.size() == FRAME) begin
        w = '0;
        for (int i = 0; i < W; i++) w[W-1-i] = bq[i];
        par = 1'b0;
        for (int i = 0; i < FRAME; i++) par = par ^ bq[i];
        if (FRAME != W && par != 1'b1) m_perr = 1'b1;
        bq.delete();
        if (exp_q.size() != 0) m_ovr = 1'b1;
        else exp_q.push_back(w);
      end
    end
  end

  // Monitor: the front of exp_q is the word that must be on data_out.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("overrun", overrun, m_ovr);
      chk("bit_cnt", bit_cnt, bq.size());
`ifdef SHIFT_REG_PARITY_EN
      chk("parity_err", parity_err, m_perr);
`endif
      if (out_valid && exp_q.size() != 0) begin
        chk("data_out", data_out, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    shift = 1'b1;
    sin   = b;
    tick();
    shift = 1'b0;
    sin   = 1'($urandom);
  endtask

  task automatic send_word(input logic [W-1:0] w, input int maxgap,
                           input bit badpar);
    for (int i = 0; i < FRAME; i++) begin
      if (i != 0 && maxgap != 0) repeat ($urandom_range(maxgap, 1)) tick();
      if (i < W) send_bit(w[W-1-i]);
      else send_bit(~(^w) ^ badpar);
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; sin = 1'b0; shift = 1'b0;
    clear = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    chk("rst data_out", data_out, 0);
    chk("rst out_valid", out_valid, 0);

    send_word(8'hAA, 0, 0);
    chk("t1 valid", out_valid, 1);
    chk("t1 data", data_out, 8'hAA);
    chk("t1 bit_cnt", bit_cnt, 0);
    chk("t1 overrun", overrun, 0);
    accept();

    send_word(8'hAA, 3, 0);
    chk("t2 data", data_out, 8'hAA);
    accept();

    out_ready = 1'b1;
    send_word(8'hAA, 0, 0);
    chk("t3 first", data_out, 8'hAA);
    send_word(8'hCC, 0, 0);
    chk("t3 second", data_out, 8'hCC);
    chk("t3 overrun", overrun, 0);
    tick();
    out_ready = 1'b0;

    send_word(8'hAA, 0, 0);
    send_word(8'hCC, 0, 0);
    chk("t4 held", data_out, 8'hAA);
    chk("t4 overrun", overrun, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t4 clr ovr", overrun, 0);
    chk("t4 clr valid", out_valid, 1);
    accept();
    chk("t4 drained", out_valid, 0);

    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    send_word(8'h55, 0, 0);
    chk("t5 clear", data_out, 8'h55);
    accept();
    for (int i = 0; i < 3; i++) send_bit(1'($urandom));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5 rst data", data_out, 0);
    chk("t5 rst cnt", bit_cnt, 0);
    send_word(8'h55, 0, 0);
    chk("t5 after rst", data_out, 8'h55);
    accept();

`ifdef SHIFT_REG_PARITY_EN
    send_word(8'hAA, 0, 0);
    chk("t6 good par", parity_err, 0);
    accept();
    send_word(8'hAA, 0, 1);
    chk("t6 bad data", data_out, 8'hAA);
    chk("t6 bad par", parity_err, 1);
    accept();
`endif

    for (int n = 0; n < 2000; n++) begin
      shift     = ($urandom_range(3, 0) != 0);
      sin       = 1'($urandom);
      out_ready = ($urandom_range(2, 0) == 0);
      clear     = ($urandom_range(60, 0) == 0);
      reset     = ($urandom_range(250, 0) == 0);
      tick();
    end
    reset = 1'b0; clear = 1'b0; shift = 1'b0; out_ready = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
